// File: rtl/tori_pkg.sv
// tori_pkg: shared port indices, defaults and types for the torus router.
package tori_pkg;
  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST = 2;
  localparam int SOUTH = 3;
  localparam int WEST = 4;
  localparam int N_PORTS_DEFAULT = 5;
  localparam int FIFO_WIDTH_DEFAULT = 32;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  typedef logic [FIFO_WIDTH_DEFAULT-1:0] flit_t;
endpackage

// File: rtl/tori_rr_picker.sv
// tori_rr_picker: combinational round-robin priority search starting at rrPtr.
module tori_rr_picker
  import tori_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEFAULT,
  parameter int PTR_W = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] reqValid,
  input  logic [PTR_W-1:0]   rrPtr,
  input  logic               enable,
  output logic [N_PORTS-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               anyGrant
);
  logic [PTR_W-1:0] idx;
  // Walk from the farthest offset down so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    winner = '0;
    anyGrant = 1'b0;
    idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rrPtr) + k) % N_PORTS);
      if (enable && reqValid[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        winner = idx;
        anyGrant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tori_output_arbiter.sv
// tori_output_arbiter: round-robin share of one output link with a one-entry output stage.
module tori_output_arbiter
  import tori_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int N_PORTS = N_PORTS_DEFAULT,
  localparam int PTR_W = $clog2(N_PORTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_PORTS-1:0]           reqValid,
  input  logic [N_PORTS*FIFO_WIDTH-1:0] reqData,
  output logic [N_PORTS-1:0]           readRequest,
  output logic [FIFO_WIDTH-1:0]        outData,
  output logic                         outWriteRequest,
  input  logic                         outHoldRequest
);
  state_t state, state_n;
  logic [PTR_W-1:0] rr_ptr, winner;
  logic can_load, any_grant;
  assign can_load = (state == EMPTY) || !outHoldRequest;
  assign outWriteRequest = (state == FULL);
  tori_rr_picker #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) picker (
    .reqValid(reqValid),
    .rrPtr(rr_ptr),
    .enable(can_load && !reset),
    .grant(readRequest),
    .winner(winner),
    .anyGrant(any_grant)
  );
  // A grant always refills; otherwise the flit stays only while held.
  always_comb begin
    state_n = EMPTY;
    state_n = (any_grant || (state == FULL && outHoldRequest)) ? FULL : EMPTY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      outData <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      if (any_grant) begin
        outData <= reqData[winner*FIFO_WIDTH +: FIFO_WIDTH];
        rr_ptr <= (int'(winner) == N_PORTS - 1) ? '0 : winner + 1'b1;
      end
    end
  end
endmodule

// File: doc/tori_output_arbiter.md
Name: tori_output_arbiter

Overview:
- Per-output-port round-robin arbiter for the 2D torus router.
- Shares one router output link between the N_PORTS input FIFOs whose head flit is routed to that output.
- Pops the winning FIFO and registers the flit into a one-entry output stage.
- Drives the downstream node or router with the network's write/hold handshake.
- One instance per output direction (local, N, E, S, W) inside each router of networkTori.

Parameters:
- FIFO_WIDTH, 32, flit width in bits (one FIFO word = one single-flit packet).
- N_PORTS, 5, number of requesting input ports (local + 4 torus directions).
- PTR_W, $clog2(N_PORTS), width of the round-robin pointer (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  N_PORTS  bit i = input FIFO i is non-empty and its head flit is routed to this output.
- reqData  in  N_PORTS*FIFO_WIDTH  head flit of each input FIFO; slice i = bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- readRequest  out  N_PORTS  one-hot pop strobe to the winning input FIFO; combinational.
- outData  out  FIFO_WIDTH  registered flit to downstream.
- outWriteRequest  out  1  outData holds a valid flit.
- outHoldRequest  in  1  downstream cannot accept this cycle.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - outWriteRequest=0, outData=0, rrPtr=0, state=EMPTY.
  - readRequest is forced to all-zero while reset=1.
  - A flit held in the output stage during reset is discarded, never replayed.
- States: EMPTY (stage free) and FULL (stage holds a flit); outWriteRequest = (state==FULL).
- Transfer: a flit leaves on any edge where outWriteRequest=1 and outHoldRequest=0.
- canLoad = (state==EMPTY) || (outHoldRequest==0). Arbitration occurs only when canLoad=1 and reqValid!=0.
- Winner: the first index i with reqValid[i]=1, searching rrPtr, rrPtr+1, ... N_PORTS-1, 0, ... rrPtr-1 (wrap modulo N_PORTS).
- Grant cycle:
  - readRequest[winner]=1 in that same cycle.
  - At the next edge: outData <- reqData[winner], state=FULL, rrPtr <- (winner+1) mod N_PORTS.
  - winner=N_PORTS-1 wraps rrPtr to 0.
- No grant: rrPtr is unchanged.
- Latency: a request seen in EMPTY produces outWriteRequest=1 on the following cycle.
  - Back-to-back: sustained 1 flit/cycle while outHoldRequest=0.
- Transitions:
  - EMPTY: grant -> FULL; no request -> EMPTY.
  - FULL and hold=1: stay FULL. outData stable, readRequest=0, rrPtr frozen.
  - FULL and hold=0: grant -> FULL with the new flit (simultaneous drain and load); no request -> EMPTY.
- Hold asserted while EMPTY has no effect; loading is still allowed.
- readRequest is at most one-hot, never asserted without a matching reqValid bit, and never asserted while FULL and hold=1.
- reqValid bits that drop without a grant are ignored; there is no request latching.
- Fairness: with all ports continuously requesting, each port is granted exactly once every N_PORTS grants.

Decomposition:
- tori_pkg holds:
  - port index constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4;
  - N_PORTS_DEFAULT=5;
  - the state enum typedef {EMPTY, FULL};
  - flit_t = logic [FIFO_WIDTH-1:0].
- One sub-module: tori_rr_picker.
  - Combinational.
  - Inputs: reqValid, rrPtr, enable.
  - Outputs: one-hot grant, encoded winner index, anyGrant.
  - Arbiter owns the state, pointer and output register; the picker owns priority rotation only.

Test Plan:
- Reset check: hold reset=1 for 2 cycles with reqValid=5'b11111 -> readRequest=0, outWriteRequest=0, outData=0. After release, first grant goes to port 0.
- Single request: reqValid=5'b00100, reqData[2]=32'h81FFFFFF, hold=0 -> readRequest=5'b00100 for 1 cycle; next cycle outWriteRequest=1, outData=32'h81FFFFFF; following cycle outWriteRequest=0.
- Round-robin with all ports requesting and hold=0 for 10 cycles -> grant order 0,1,2,3,4,0,1,2,3,4; outData matches each port's tagged flit in that order.
- Backpressure: stage FULL with port 1's flit, hold=1 for 3 cycles with reqValid=5'b01010 -> outData stable, readRequest=0, rrPtr stays 2. On hold=0, readRequest=5'b01000 and port 3's flit loads in the same cycle port 1's flit drains.
- Wrap: rrPtr=4, reqValid=5'b10001 -> grant port 4, rrPtr becomes 0; next grant port 0.
- Reset mid-operation: assert reset while FULL and hold=1 -> next edge outWriteRequest=0, the flit is lost, rrPtr=0.
